// File: rtl/ram_wait_responder.sv
// Wait-state RAM responder: 256x8 big-endian store behind a four-phase MOV/MOC handshake.
// Define RAM_ALIGN_CHECK_EN to flag and suppress misaligned halfword/word accesses via ERR.
module ram_wait_responder #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MOV,
    input  logic        ReadWrite,
    input  logic [2:0]  MS_2_0,
    input  logic [31:0] DataIn,
    input  logic [31:0] Address,
    output logic        MOC,
    output logic [31:0] DataOut,
    output logic        ERR
);

    // state  | meaning
    // IDLE   | waiting for MOV=1; request fields latched on the sampling edge
    // ACCESS | counting down wait cycles; access performed when counter is zero
    // DONE   | MOC held high until MOV is sampled low
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [2:0]  ms_q, ms_d;
    logic [31:0] din_q, din_d;
    logic        moc_q, moc_d;
    logic        err_q, err_d;
    logic [31:0] dout_q, dout_d;
    logic        mem_we;

    logic [7:0]  memory [0:255];

    logic [7:0]  a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    logic        is_byte, is_half;
    logic [31:0] rd_val;
    logic        misaligned;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^Address[31:8];

    // 8-bit address arithmetic gives the wrap from 255 to 0 for free
    assign a1 = addr_q + 8'd1;
    assign a2 = addr_q + 8'd2;
    assign a3 = addr_q + 8'd3;

    assign b0 = memory[addr_q];
    assign b1 = memory[a1];
    assign b2 = memory[a2];
    assign b3 = memory[a3];

    assign is_byte = (ms_q[1:0] == 2'b00);
    assign is_half = (ms_q[1:0] == 2'b01);

`ifdef RAM_ALIGN_CHECK_EN
    assign misaligned = (is_half && addr_q[0]) ||
                        (!is_byte && !is_half && (addr_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        rd_val = {b0, b1, b2, b3};
        if (is_byte) begin
            rd_val = {{24{ms_q[2] & b0[7]}}, b0};
        end else if (is_half) begin
            rd_val = {{16{ms_q[2] & b0[7]}}, b0, b1};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        ms_d    = ms_q;
        din_d   = din_q;
        moc_d   = moc_q;
        err_d   = err_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    addr_d  = Address[7:0];
                    rw_d    = ReadWrite;
                    ms_d    = MS_2_0;
                    din_d   = DataIn;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    moc_d   = 1'b1;
                    err_d   = misaligned;
                    state_d = DONE;
                    if (!misaligned) begin
                        if (rw_q) dout_d = rd_val;
                        else      mem_we = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!MOV) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 8'd0;
            rw_q    <= 1'b0;
            ms_q    <= 3'd0;
            din_q   <= 32'd0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            ms_q    <= ms_d;
            din_q   <= din_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is never cleared by reset; a write only lands outside reset
    always_ff @(posedge CLK) begin
        if (RESET_N && mem_we) begin
            if (is_byte) begin
                memory[addr_q] <= din_q[7:0];
            end else if (is_half) begin
                memory[addr_q] <= din_q[15:8];
                memory[a1]     <= din_q[7:0];
            end else begin
                memory[addr_q] <= din_q[31:24];
                memory[a1]     <= din_q[23:16];
                memory[a2]     <= din_q[15:8];
                memory[a3]     <= din_q[7:0];
            end
        end
    end

    assign MOC     = moc_q;
    assign DataOut = dout_q;
    assign ERR     = err_q;

endmodule
